// File: rtl/cpu_dma_scheduler.sv
// cpu_dma_scheduler: owns the CPU bus during OAM sprite DMA ($4014 write) and,
// when NES_DMC_DMA_EN is defined, APU DMC sample fetches. Runs 2A03-style
// GET/PUT cycles locked to CPU cycle parity; a pending DMC read takes the next
// GET slot ahead of the OAM read. With NES_DMC_DMA_EN undefined the DMC ports
// are present but ignored, and DMC_ACK/DMC_DATA are held at 0.
//
// Handshake: DMC_REQ is a level. DMC_ACK is high for exactly one CE cycle,
// the cycle in which DMC_DATA carries the fetched byte; the requester lowers
// DMC_REQ on the clock edge that samples DMC_ACK. DMA_RD/OAM_WR are strobes
// that mean "this CE cycle"; with CE low they hold but nothing advances.
module cpu_dma_scheduler #(
    parameter logic [15:0] PAGE_REG = 16'h4014
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_DATA_OUT,
    input  logic        CPU_RW_n,
    input  logic [7:0]  BUS_DATA_IN,
    input  logic        DMC_REQ,
    input  logic [15:0] DMC_ADDR,
    output logic        CPU_HALT,
    output logic        DMA_ACTIVE,
    output logic [15:0] DMA_ADDR,
    output logic        DMA_RD,
    output logic        OAM_WR,
    output logic [7:0]  OAM_ADDR,
    output logic [7:0]  OAM_DATA,
    output logic        DMC_ACK,
    output logic [7:0]  DMC_DATA,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_GET   = 3'd3,
        S_PUT   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        par;        // 0 = GET slot, 1 = PUT slot
    logic [7:0]  idx;
    logic [7:0]  page;
    logic [7:0]  data_buf;
    logic        oam_pend;
    logic        trigger;
    logic        dmc_pend;
    logic        oam_get;

    assign dbg_state = state;

    // Request decode: $4014 write starts OAM DMA unless one is already queued
    always_comb begin
        trigger = CE & ~CPU_RW_n & (CPU_ADDR == PAGE_REG) & ~oam_pend;
`ifdef NES_DMC_DMA_EN
        dmc_pend = DMC_REQ;
`else
        dmc_pend = 1'b0;
`endif
    end

`ifndef NES_DMC_DMA_EN
    logic unused_dmc;
    assign unused_dmc = ^{DMC_REQ, DMC_ADDR};
`endif

    // Next-state and output decode; every output is a function of state
    always_comb begin
        state_nxt  = state;
        CPU_HALT   = 1'b0;
        DMA_ACTIVE = 1'b0;
        DMA_ADDR   = 16'h0000;
        DMA_RD     = 1'b0;
        OAM_WR     = 1'b0;
        OAM_ADDR   = 8'h00;
        OAM_DATA   = 8'h00;
        DMC_ACK    = 1'b0;
        DMC_DATA   = 8'h00;
        oam_get    = 1'b0;
        if (state != S_IDLE) begin
            CPU_HALT   = 1'b1;
            DMA_ACTIVE = 1'b1;
        end
        case (state)
            S_IDLE: begin
                // The trigger edge itself moves to HALT so the CPU stops next cycle
                if (oam_pend || trigger || dmc_pend) state_nxt = S_HALT;
            end
            S_HALT: begin
                // par=1 now means the following cycle is a GET slot
                state_nxt = par ? S_GET : S_ALIGN;
            end
            S_ALIGN: begin
                state_nxt = S_GET;
            end
            S_GET: begin
                if (dmc_pend) begin
                    DMA_ADDR  = DMC_ADDR;
                    DMA_RD    = 1'b1;
                    DMC_ACK   = 1'b1;
                    DMC_DATA  = BUS_DATA_IN;
                    state_nxt = oam_pend ? S_ALIGN : S_IDLE;
                end else if (oam_pend) begin
                    DMA_ADDR  = {page, idx};
                    DMA_RD    = 1'b1;
                    oam_get   = 1'b1;
                    state_nxt = S_PUT;
                end else begin
                    // DMC request withdrawn before its slot: release the bus
                    state_nxt = S_IDLE;
                end
            end
            S_PUT: begin
                OAM_WR   = 1'b1;
                OAM_ADDR = idx;
                OAM_DATA = data_buf;
                if (idx == 8'hFF) state_nxt = dmc_pend ? S_GET : S_IDLE;
                else              state_nxt = S_GET;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, parity, OAM index, page and read buffer; everything holds when CE is low
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            par      <= 1'b0;
            idx      <= 8'h00;
            page     <= 8'h00;
            data_buf <= 8'h00;
            oam_pend <= 1'b0;
        end else if (CE) begin
            state <= state_nxt;
            par   <= ~par;
            if (trigger) begin
                page     <= CPU_DATA_OUT;
                oam_pend <= 1'b1;
            end
            if (oam_get) data_buf <= BUS_DATA_IN;
            if (state == S_PUT) begin
                idx <= idx + 8'd1;
                if (idx == 8'hFF) oam_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_dma_scheduler.sv
// Bench for cpu_dma_scheduler: directed transfers, expected bus reads, OAM
// writes and DMC bytes are queued by the driver and drained by a monitor.
module tb_cpu_dma_scheduler;

    localparam int M_NONE   = 0;
    localparam int M_RETRIG = 1;
    localparam int M_DMC    = 2;
    localparam int M_CE     = 3;
    localparam int M_RST    = 4;

    logic        CLK;
    logic        RESET;
    logic        CE;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_DATA_OUT;
    logic        CPU_RW_n;
    logic [7:0]  BUS_DATA_IN;
    logic        DMC_REQ;
    logic [15:0] DMC_ADDR;
    logic        CPU_HALT;
    logic        DMA_ACTIVE;
    logic [15:0] DMA_ADDR;
    logic        DMA_RD;
    logic        OAM_WR;
    logic [7:0]  OAM_ADDR;
    logic [7:0]  OAM_DATA;
    logic        DMC_ACK;
    logic [7:0]  DMC_DATA;
    logic [2:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic m_par;

    logic [15:0] rd_q[$];
    logic [15:0] wr_q[$];
    logic [7:0]  dmc_q[$];
    logic [15:0] e16;
    logic [7:0]  e8;

    cpu_dma_scheduler dut (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .CPU_ADDR(CPU_ADDR), .CPU_DATA_OUT(CPU_DATA_OUT), .CPU_RW_n(CPU_RW_n),
        .BUS_DATA_IN(BUS_DATA_IN), .DMC_REQ(DMC_REQ), .DMC_ADDR(DMC_ADDR),
        .CPU_HALT(CPU_HALT), .DMA_ACTIVE(DMA_ACTIVE), .DMA_ADDR(DMA_ADDR),
        .DMA_RD(DMA_RD), .OAM_WR(OAM_WR), .OAM_ADDR(OAM_ADDR), .OAM_DATA(OAM_DATA),
        .DMC_ACK(DMC_ACK), .DMC_DATA(DMC_DATA), .dbg_state(dbg_state)
    );

    // Clock and reset block
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference CPU cycle parity: 0 after reset, toggles on every CE cycle
    always @(posedge CLK) begin
        if (RESET)   m_par <= 1'b0;
        else if (CE) m_par <= ~m_par;
    end

    // Memory contents seen on the CPU bus
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return (a[7:0] * 8'd3) ^ a[15:8] ^ 8'h5A;
    endfunction

    assign BUS_DATA_IN = DMA_RD ? mem_byte(DMA_ADDR) : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes in a CE cycle
    always @(negedge CLK) begin
        if (CE) begin
            if (DMA_RD) begin
                if (rd_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rd_unexpected: got addr %h expected no read", DMA_ADDR);
                end else begin
                    e16 = rd_q.pop_front();
                    check("rd_addr", {16'h0, DMA_ADDR}, {16'h0, e16});
                end
            end
            if (OAM_WR) begin
                if (wr_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL oam_unexpected: got %h/%h expected no write", OAM_ADDR, OAM_DATA);
                end else begin
                    e16 = wr_q.pop_front();
                    check("oam_wr", {16'h0, OAM_ADDR, OAM_DATA}, {16'h0, e16});
                end
            end
            if (DMC_ACK) begin
                if (dmc_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL dmc_unexpected: got ack data %h expected no ack", DMC_DATA);
                end else begin
                    e8 = dmc_q.pop_front();
                    check("dmc_data", {24'h0, DMC_DATA}, {24'h0, e8});
                end
            end
        end
    end

    // Follows one halt window, injecting the mode's event; counts CE cycles with CPU_HALT
    task automatic watch(input int mode, output int cyc);
        int  guard;
        int  ce_hold;
        bit  drop_req;
        bit  ev_done;
        bit  restore_bus;
        cyc = 0; guard = 0; ce_hold = 0;
        drop_req = 1'b0; ev_done = 1'b0; restore_bus = 1'b0;
        while (CPU_HALT && guard < 3000) begin
            if (drop_req) begin
                DMC_REQ  = 1'b0;
                drop_req = 1'b0;
            end
            if (restore_bus) begin
                CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1; CPU_DATA_OUT = 8'h00;
                restore_bus = 1'b0;
            end
            if (DMC_ACK && CE) drop_req = 1'b1;
            case (mode)
                M_RETRIG: if (!ev_done && OAM_WR && OAM_ADDR == 8'd20) begin
                    CPU_ADDR = 16'h4014; CPU_RW_n = 1'b0; CPU_DATA_OUT = 8'h33;
                    restore_bus = 1'b1; ev_done = 1'b1;
                end
                M_DMC: if (!ev_done && OAM_WR && OAM_ADDR == 8'd9) begin
                    DMC_ADDR = 16'hC123; DMC_REQ = 1'b1; ev_done = 1'b1;
                end
                M_CE: begin
                    if (ce_hold > 0) begin
                        ce_hold--;
                        if (ce_hold == 0) CE = 1'b1;
                    end else if (!ev_done && OAM_WR && OAM_ADDR == 8'd50) begin
                        CE = 1'b0; ce_hold = 5; ev_done = 1'b1;
                    end
                end
                M_RST: if (!ev_done && OAM_WR && OAM_ADDR == 8'd100) begin
                    RESET = 1'b1; ev_done = 1'b1;
                end
                default: ;
            endcase
            if (CE) cyc++;
            tick();
            guard++;
        end
        DMC_REQ = 1'b0;
        if (guard >= 3000) begin
            n_cmp++; n_fail++;
            $display("FAIL halt_timeout: got CPU_HALT stuck after %0d cycles expected release", guard);
        end
    endtask

    // Driver: queue expectations, then issue the $4014 write at the chosen parity
    task automatic run_oam(input logic [7:0] page, input bit align, input int mode,
                           input int n_bytes, input int exp_cyc);
        int          cyc;
        logic [15:0] a;
        while (m_par != align) tick();
        for (int i = 0; i < n_bytes; i++) begin
            a = {page, i[7:0]};
            if (mode == M_DMC && i == 10) begin
                rd_q.push_back(16'hC123);
                dmc_q.push_back(mem_byte(16'hC123));
            end
            rd_q.push_back(a);
            wr_q.push_back({i[7:0], mem_byte(a)});
        end
        CPU_ADDR = 16'h4014; CPU_DATA_OUT = page; CPU_RW_n = 1'b0;
        tick();
        CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00; CPU_RW_n = 1'b1;
        watch(mode, cyc);
        check("halt_cycles", cyc, exp_cyc);
        check("rd_left", rd_q.size(), 0);
        check("wr_left", wr_q.size(), 0);
        check("dmc_left", dmc_q.size(), 0);
    endtask

    // Driver: standalone DMC fetch issued while idle at a chosen parity
    task automatic run_dmc_alone(input logic [15:0] addr, input bit par);
        int cyc;
        while (m_par != par) tick();
        rd_q.push_back(addr);
        dmc_q.push_back(mem_byte(addr));
        DMC_ADDR = addr; DMC_REQ = 1'b1;
        tick();
        watch(M_NONE, cyc);
        check("dmc_halt_cycles", cyc, par ? 3 : 2);
        repeat (3) tick();
        check("dmc_idle_after", {29'h0, dbg_state}, 32'h0);
        check("dmc_left", dmc_q.size(), 0);
        check("dmc_rd_left", rd_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {27'h0, CPU_HALT, DMA_ACTIVE, DMA_RD, OAM_WR, DMC_ACK}, 32'h0);
        check({tag, "_addr"}, {16'h0, DMA_ADDR}, 32'h0);
        check({tag, "_data"}, {8'h0, OAM_ADDR, OAM_DATA, DMC_DATA}, 32'h0);
    endtask

    // Stimulus sequence and final report
    initial begin
        RESET = 1'b1; CE = 1'b1; CPU_ADDR = 16'h0000; CPU_DATA_OUT = 8'h00;
        CPU_RW_n = 1'b1; DMC_REQ = 1'b0; DMC_ADDR = 16'h0000;
        repeat (3) tick();
        check_outputs_zero("reset");
        RESET = 1'b0;
        repeat (2) tick();

        run_oam(8'h07, 1'b0, M_NONE, 256, 513);
        repeat (3) tick();
        run_oam(8'h07, 1'b1, M_RETRIG, 256, 514);
        repeat (3) tick();
`ifdef NES_DMC_DMA_EN
        run_oam(8'h07, 1'b0, M_DMC, 256, 515);
        repeat (3) tick();
        run_dmc_alone(16'hC123, 1'b0);
        run_dmc_alone(16'h8F41, 1'b1);
`else
        DMC_ADDR = 16'hC123; DMC_REQ = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("dmc_ignored", {23'h0, CPU_HALT, DMC_ACK, DMC_DATA}, 32'h0);
        end
        DMC_REQ = 1'b0;
        tick();
`endif
        run_oam(8'h12, 1'b0, M_CE, 256, 513);
        repeat (3) tick();
        run_oam(8'h07, 1'b0, M_RST, 101, 203);
        check_outputs_zero("mid_reset");
        RESET = 1'b0;
        repeat (2) tick();
        run_oam(8'h07, 1'b1, M_NONE, 256, 514);
        repeat (4) tick();
        check_outputs_zero("final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_dma_scheduler.md
# cpu_dma_scheduler

Sequences all DMA traffic on the CPU bus: OAM sprite DMA (triggered by a CPU write to $4014) and, optionally, APU DMC sample fetches. It halts the CPU, takes the bus, and runs 2A03-accurate get/put cycles aligned to CPU cycle parity. It arbitrates DMC reads against OAM gets, with DMC first. It sits between the CPU core, the CPU bus mux and the PPU OAM write port, and replaces the ad-hoc DMA counter in the top level.

## Interface
- PAGE_REG, 16'h4014, CPU write address that starts an OAM DMA
- CLK  in  1  CPU clock
- RESET  in  1  synchronous, active-high reset
- CE  in  1  clock enable; all state, including parity, holds when low
- CPU_ADDR  in  16  CPU address
- CPU_DATA_OUT  in  8  CPU write data
- CPU_RW_n  in  1  1 = read, 0 = write
- BUS_DATA_IN  in  8  CPU bus read data; valid in the same cycle as DMA_RD
- DMC_REQ  in  1  level request for one DMC sample byte
- DMC_ADDR  in  16  DMC fetch address; held stable while DMC_REQ is high
- CPU_HALT  out  1  gates CPU enable low
- DMA_ACTIVE  out  1  scheduler owns the bus; bus mux selects DMA_ADDR
- DMA_ADDR  out  16  bus address during DMA reads
- DMA_RD  out  1  bus read strobe
- OAM_WR  out  1  OAM write strobe to PPU
- OAM_ADDR  out  8  OAM byte index
- OAM_DATA  out  8  byte to write
- DMC_ACK  out  1  one-cycle pulse; DMC_DATA valid this cycle
- DMC_DATA  out  8  fetched sample byte

## Operation
- `par` toggles on every CE cycle; it is 0 after reset. Even cycles (par=0) are GET slots; odd cycles are PUT slots.
- Trigger: CE & ~CPU_RW_n & CPU_ADDR==PAGE_REG.
  - Latches `page` = CPU_DATA_OUT and sets `oam_pend`.
  - Ignored while `oam_pend` is already set.
- The DMC is pending whenever DMC_REQ=1.
- States:
  - IDLE: if `oam_pend` or DMC pending → HALT.
  - HALT: one cycle with CPU_HALT=1. If the next cycle is a GET slot → GET, else → ALIGN.
  - ALIGN: one idle cycle → GET.
  - GET:
    - If DMC is pending: DMC read.
      - DMA_ADDR=DMC_ADDR, DMA_RD=1, DMC_ACK=1, DMC_DATA=BUS_DATA_IN.
      - Next: ALIGN if `oam_pend`, else IDLE.
    - Otherwise: OAM read.
      - DMA_ADDR={page, idx}, DMA_RD=1; BUS_DATA_IN is latched into `buf`.
      - Next: PUT.
  - PUT: OAM_WR=1, OAM_ADDR=idx, OAM_DATA=`buf`; idx increments mod 256.
    - If idx was 255: clear `oam_pend`, then → IDLE, or → GET if DMC is pending.
    - Otherwise → GET.
- CPU_HALT and DMA_ACTIVE are both 1 in every state except IDLE.
- `idx` is 8 bits, starts at 0 and wraps to 0 after 255.
- Simultaneous trigger and DMC_REQ: the DMC is served in the first GET slot, then OAM byte 0.
- Reset mid-operation:
  - State → IDLE; idx, par, page, `buf` and `oam_pend` → 0.
  - The partial OAM transfer is abandoned, not resumed.

## Timing
- Reset values: all outputs are 0.
- DMA_ADDR, OAM_ADDR, OAM_DATA and DMC_DATA are 0 whenever their strobe is low.
- The trigger is sampled at edge T. CPU_HALT rises in cycle T+1 (HALT) and stays high through the final PUT.
- OAM DMA with no DMC traffic:
  - 513 cycles when HALT is followed directly by a GET slot.
  - 514 cycles when an ALIGN cycle is needed.
- Each DMC steal inside an OAM transfer adds 2 cycles (DMC GET + ALIGN).
- Standalone DMC fetch takes 2 or 3 cycles: HALT, optional ALIGN, GET.
- DMC_ACK pulses exactly one CE cycle per DMC fetch. The requester drops DMC_REQ on the edge that samples DMC_ACK.
- Outputs are registered-state decodes. Read data is combinational only in DMC_DATA; `buf` is registered.

## Configuration
- NES_DMC_DMA_EN defined: DMC arbitration operates as above.
- Undefined:
  - DMC_REQ and DMC_ADDR are ignored; DMC_ACK and DMC_DATA are tied 0.
  - GET always performs the OAM read.
  - Ports remain present.

## Test plan
- Trigger write $07 at $4014 with par aligned so HALT is followed by a GET slot → 513 cycles of CPU_HALT; 256 OAM_WR pulses, OAM_ADDR 0..255, reads from $0700..$07FF; OAM_DATA equals memory contents.
- Same trigger one cycle later (HALT followed by a PUT slot) → one ALIGN cycle, 514-cycle halt, identical OAM contents.
- With the macro on, assert DMC_REQ (DMC_ADDR=$C123) at OAM byte 10 → one DMC_ACK with DMC_DATA=mem[$C123]; OAM byte 10 is read from $070A afterward; total 515/516 cycles; no byte skipped or duplicated.
- Standalone DMC_REQ while idle → CPU_HALT for 2–3 cycles, one DMC_ACK, return to IDLE.
- Assert RESET at OAM byte 100 → next cycle all outputs 0, CPU released; a new trigger restarts at OAM_ADDR 0.
- Hold CE low for 5 cycles mid-transfer → no state, idx or par change; transfer resumes with unchanged cycle count.
